// File: rtl/msg_display_driver_if.sv
// Message bus between the maintenance FSM and the 3-digit display driver.
// The FSM side supplies the message; the driver side returns display drive and status.
interface msg_display_driver_if;
  logic [7:0] msj_in;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;
  logic       alarm;

  modport master (output msj_in, input seg, an, busy, alarm);
  modport slave  (input msj_in, output seg, an, busy, alarm);
endinterface

// File: rtl/msg_display_driver.sv
// Sequential binary-to-BCD conversion of the FSM message, shown on a multiplexed
// common-anode 3-digit display; the alarm code is shown as a blinking "Err".
module msg_display_driver #(
  parameter int         REFRESH_DIV = 50000,
  parameter int         BLINK_DIV   = 25000000,
  parameter logic [7:0] ALARM_CODE  = 8'hFF
) (
  input logic clk,
  input logic rst,
  msg_display_driver_if.slave bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [7:0]  last_val;
  logic [7:0]  bin_shadow;
  logic [11:0] bcd_shift;
  logic [2:0]  iter;
  logic [3:0]  disp_h, disp_t, disp_u;
  logic        busy_q, alarm_q;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [6:0]    seg_q, seg_next;
  logic [2:0]    an_q, an_next;

  // One double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dabble(input logic [11:0] b, input logic bit_in);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++) begin
      if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a[10:0], bit_in};
  endfunction

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = 7'b1000000;
      4'd1:    digit_code = 7'b1111001;
      4'd2:    digit_code = 7'b0100100;
      4'd3:    digit_code = 7'b0110000;
      4'd4:    digit_code = 7'b0011001;
      4'd5:    digit_code = 7'b0010010;
      4'd6:    digit_code = 7'b0000010;
      4'd7:    digit_code = 7'b1111000;
      4'd8:    digit_code = 7'b0000000;
      4'd9:    digit_code = 7'b0010000;
      default: digit_code = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_val   <= 8'd0;
      bin_shadow <= 8'd0;
      bcd_shift  <= 12'd0;
      iter       <= 3'd0;
      disp_h     <= 4'd0;
      disp_t     <= 4'd0;
      disp_u     <= 4'd0;
      busy_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.msj_in != last_val) begin
            last_val   <= bus.msj_in;
            bin_shadow <= bus.msj_in;
            bcd_shift  <= 12'd0;
            iter       <= 3'd0;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_shift  <= dabble(bcd_shift, bin_shadow[7]);
          bin_shadow <= {bin_shadow[6:0], 1'b0};
          iter       <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          disp_h  <= bcd_shift[11:8];
          disp_t  <= bcd_shift[7:4];
          disp_u  <= bcd_shift[3:0];
          alarm_q <= (last_val == ALARM_CODE);
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Leading-zero blanking in normal mode; fixed "Err" glyphs in alarm mode.
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 3'b111;
    case (scan_idx)
      2'd0: begin
        an_next  = 3'b110;
        seg_next = alarm_q ? SEG_R : digit_code(disp_u);
      end
      2'd1: begin
        an_next  = 3'b101;
        if (alarm_q)                              seg_next = SEG_R;
        else if (disp_h == 4'd0 && disp_t == 4'd0) seg_next = SEG_BLANK;
        else                                      seg_next = digit_code(disp_t);
      end
      2'd2: begin
        an_next  = 3'b011;
        if (alarm_q)             seg_next = SEG_E;
        else if (disp_h == 4'd0) seg_next = SEG_BLANK;
        else                     seg_next = digit_code(disp_h);
      end
      default: ;
    endcase
    if (alarm_q && !blink_on) an_next = 3'b111;
  end

  // Scan and blink timing; the blink counter idles in the ON phase outside alarm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      seg_q       <= 7'b1000000;
      an_q        <= 3'b110;
    end else begin
      if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (!alarm_q) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.busy  = busy_q;
  assign bus.alarm = alarm_q;

endmodule

// File: tb/tb_msg_display_driver.sv
// Directed bench for msg_display_driver with small scan/blink dividers; a second
// instance with the alarm code moved to 0 lets 255 be shown as a number.
module tb_msg_display_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;

  msg_display_driver_if ifc_a ();
  msg_display_driver_if ifc_b ();

  msg_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(16), .ALARM_CODE(8'hFF)) dut_a (
    .clk(clk), .rst(rst), .bus(ifc_a)
  );
  msg_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(16), .ALARM_CODE(8'h00)) dut_b (
    .clk(clk), .rst(rst), .bus(ifc_b)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] AN_U = 3'b110;
  localparam logic [2:0] AN_T = 3'b101;
  localparam logic [2:0] AN_H = 3'b011;

  // Waits (bounded) for the requested digit slot and returns its segments; x on timeout.
  task automatic capture(input bit sel, input logic [2:0] an_val, output logic [6:0] seg_val);
    bit found = 1'b0;
    seg_val = 'x;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ((sel ? ifc_b.an : ifc_a.an) == an_val) begin
        seg_val = sel ? ifc_b.seg : ifc_a.seg;
        found = 1'b1;
      end
    end
  endtask

  task automatic convert(input logic [7:0] v, output int busy_len);
    busy_len = 0;
    ifc_a.msj_in = v;
    for (int i = 0; i < 4 && !ifc_a.busy; i++) @(negedge clk);
    while (ifc_a.busy && busy_len < 30) begin
      busy_len++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [2:0] prev_an, exp_next;
    logic [6:0] exp_seg;
    int run;
    bit seen, busy_seen;
    repeat (2) @(negedge clk);
    compared++; if (ifc_a.an !== 3'b110) begin mismatched++; $display("[TB] FAIL reset_an: got %b want 110", ifc_a.an); end
    compared++; if (ifc_a.seg !== 7'b1000000) begin mismatched++; $display("[TB] FAIL reset_seg: got %b want 1000000", ifc_a.seg); end
    compared++; if (ifc_a.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", ifc_a.busy); end
    compared++; if (ifc_a.alarm !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_alarm: got %b want 0", ifc_a.alarm); end
    rst = 1'b0;
    prev_an = ifc_a.an;
    run = 1;
    seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifc_a.busy !== 1'b0) busy_seen = 1'b1;
      if (ifc_a.an !== prev_an) begin
        case (prev_an)
          AN_U:    exp_next = AN_T;
          AN_T:    exp_next = AN_H;
          default: exp_next = AN_U;
        endcase
        compared++; if (ifc_a.an !== exp_next) begin mismatched++; $display("[TB] FAIL scan_order: got %b want %b", ifc_a.an, exp_next); end
        if (seen) begin
          compared++; if (run !== 4) begin mismatched++; $display("[TB] FAIL scan_period: got %0d want 4", run); end
        end
        seen = 1'b1;
        run = 1;
        prev_an = ifc_a.an;
      end else begin
        run++;
      end
      exp_seg = (ifc_a.an == AN_U) ? 7'b1000000 : 7'b1111111;
      compared++; if (ifc_a.seg !== exp_seg) begin mismatched++; $display("[TB] FAIL idle_seg: an %b got %b want %b", ifc_a.an, ifc_a.seg, exp_seg); end
    end
    compared++; if (busy_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: busy rose with msj_in unchanged, want never"); end
    compared++; if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL scan_moves: an never changed, want scanning"); end
  endtask

  task automatic test_convert_123;
    int len;
    logic [6:0] s;
    logic [2:0] slots [3];
    logic [6:0] want [3];
    slots = '{AN_U, AN_T, AN_H};
    want  = '{7'b0110000, 7'b0100100, 7'b1111001};
    convert(8'd123, len);
    compared++; if (len !== 9) begin mismatched++; $display("[TB] FAIL busy_len_123: got %0d want 9", len); end
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, slots[k], s);
      compared++; if (s !== want[k]) begin mismatched++; $display("[TB] FAIL digits_123[%0d]: got %b want %b", k, s, want[k]); end
    end
  endtask

  task automatic test_blanking;
    int len;
    logic [6:0] s;
    logic [2:0] slots [3];
    logic [6:0] want [3];
    slots = '{AN_U, AN_T, AN_H};
    convert(8'd7, len);
    want = '{7'b1111000, 7'b1111111, 7'b1111111};
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, slots[k], s);
      compared++; if (s !== want[k]) begin mismatched++; $display("[TB] FAIL digits_7[%0d]: got %b want %b", k, s, want[k]); end
    end
    convert(8'd100, len);
    want = '{7'b1000000, 7'b1000000, 7'b1111001};
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, slots[k], s);
      compared++; if (s !== want[k]) begin mismatched++; $display("[TB] FAIL digits_100[%0d]: got %b want %b", k, s, want[k]); end
    end
    ifc_b.msj_in = 8'd255;
    repeat (20) @(negedge clk);
    want = '{7'b0010010, 7'b0010010, 7'b0100100};
    for (int k = 0; k < 3; k++) begin
      capture(1'b1, slots[k], s);
      compared++; if (s !== want[k]) begin mismatched++; $display("[TB] FAIL digits_255[%0d]: got %b want %b", k, s, want[k]); end
    end
    compared++; if (ifc_b.alarm !== 1'b0) begin mismatched++; $display("[TB] FAIL alarm_255_b: got %b want 0", ifc_b.alarm); end
  endtask

  task automatic test_alarm_blink;
    int len, off_run, on_run;
    logic [6:0] s;
    logic [2:0] slots [3];
    logic [6:0] want [3];
    bit dark;
    slots = '{AN_U, AN_T, AN_H};
    want  = '{7'b0101111, 7'b0101111, 7'b0000110};
    convert(8'hFF, len);
    compared++; if (len !== 9) begin mismatched++; $display("[TB] FAIL busy_len_ff: got %0d want 9", len); end
    compared++; if (ifc_a.alarm !== 1'b1) begin mismatched++; $display("[TB] FAIL alarm_on: got %b want 1", ifc_a.alarm); end
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, slots[k], s);
      compared++; if (s !== want[k]) begin mismatched++; $display("[TB] FAIL digits_err[%0d]: got %b want %b", k, s, want[k]); end
    end
    for (int i = 0; i < 40 && ifc_a.an !== 3'b111; i++) @(negedge clk);
    off_run = 0;
    while (ifc_a.an === 3'b111 && off_run < 40) begin off_run++; @(negedge clk); end
    on_run = 0;
    while (ifc_a.an !== 3'b111 && on_run < 40) begin on_run++; @(negedge clk); end
    compared++; if (off_run !== 16) begin mismatched++; $display("[TB] FAIL blink_off_len: got %0d want 16", off_run); end
    compared++; if (on_run !== 16) begin mismatched++; $display("[TB] FAIL blink_on_len: got %0d want 16", on_run); end
    convert(8'd5, len);
    compared++; if (ifc_a.alarm !== 1'b0) begin mismatched++; $display("[TB] FAIL alarm_off: got %b want 0", ifc_a.alarm); end
    dark = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc_a.an === 3'b111) dark = 1'b1;
    end
    compared++; if (dark !== 1'b0) begin mismatched++; $display("[TB] FAIL blink_stopped: an went 111, want no blanking"); end
    capture(1'b0, AN_U, s);
    compared++; if (s !== 7'b0010010) begin mismatched++; $display("[TB] FAIL digits_5_units: got %b want 0010010", s); end
  endtask

  task automatic test_back_to_back;
    int n, gap, n2;
    bit rose;
    logic [6:0] s;
    ifc_a.msj_in = 8'd10;
    for (int i = 0; i < 4 && !ifc_a.busy; i++) @(negedge clk);
    n = 0;
    while (ifc_a.busy && n < 30) begin
      n++;
      if (n == 3) ifc_a.msj_in = 8'd20;
      @(negedge clk);
    end
    compared++; if (n !== 9) begin mismatched++; $display("[TB] FAIL busy_len_10: got %0d want 9", n); end
    gap = 0;
    while (!ifc_a.busy && gap < 10) begin gap++; @(negedge clk); end
    compared++; if (gap !== 1) begin mismatched++; $display("[TB] FAIL idle_gap: got %0d want 1", gap); end
    n2 = 0;
    while (ifc_a.busy && n2 < 30) begin n2++; @(negedge clk); end
    compared++; if (n2 !== 9) begin mismatched++; $display("[TB] FAIL busy_len_20: got %0d want 9", n2); end
    repeat (2) @(negedge clk);
    capture(1'b0, AN_T, s);
    compared++; if (s !== 7'b0100100) begin mismatched++; $display("[TB] FAIL digits_20_tens: got %b want 0100100", s); end
    capture(1'b0, AN_U, s);
    compared++; if (s !== 7'b1000000) begin mismatched++; $display("[TB] FAIL digits_20_units: got %b want 1000000", s); end

    ifc_a.msj_in = 8'd30;
    for (int i = 0; i < 4 && !ifc_a.busy; i++) @(negedge clk);
    n = 0;
    while (ifc_a.busy && n < 30) begin
      n++;
      if (n == 2) ifc_a.msj_in = 8'd10;
      if (n == 5) ifc_a.msj_in = 8'd30;
      @(negedge clk);
    end
    compared++; if (n !== 9) begin mismatched++; $display("[TB] FAIL busy_len_30: got %0d want 9", n); end
    rose = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc_a.busy) rose = 1'b1;
      @(negedge clk);
    end
    compared++; if (rose !== 1'b0) begin mismatched++; $display("[TB] FAIL no_reconvert: busy rose, want 0"); end
    capture(1'b0, AN_T, s);
    compared++; if (s !== 7'b0110000) begin mismatched++; $display("[TB] FAIL digits_30_tens: got %b want 0110000", s); end
  endtask

  task automatic test_reset_mid;
    int len;
    logic [6:0] s;
    logic [2:0] slots [3];
    logic [6:0] want [3];
    slots = '{AN_U, AN_T, AN_H};
    want  = '{7'b1000000, 7'b1000000, 7'b0100100};
    ifc_a.msj_in = 8'd200;
    for (int i = 0; i < 4 && !ifc_a.busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    compared++; if (ifc_a.an !== 3'b110) begin mismatched++; $display("[TB] FAIL midrst_an: got %b want 110", ifc_a.an); end
    compared++; if (ifc_a.seg !== 7'b1000000) begin mismatched++; $display("[TB] FAIL midrst_seg: got %b want 1000000", ifc_a.seg); end
    compared++; if (ifc_a.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b want 0", ifc_a.busy); end
    compared++; if (ifc_a.alarm !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_alarm: got %b want 0", ifc_a.alarm); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    convert(8'd200, len);
    compared++; if (len !== 9) begin mismatched++; $display("[TB] FAIL busy_len_200: got %0d want 9", len); end
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, slots[k], s);
      compared++; if (s !== want[k]) begin mismatched++; $display("[TB] FAIL digits_200[%0d]: got %b want %b", k, s, want[k]); end
    end
  endtask

  initial begin
    ifc_a.msj_in = 8'd0;
    ifc_b.msj_in = 8'd0;
    test_reset();
    test_convert_123();
    test_blanking();
    test_alarm_blink();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
